// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the execute / write-back datapath.
// Provides the project-wide register-file widths, the zero-register
// address, the buffered write-back entry type and the forwarding
// match helper.
package writeback_stage_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    // One pending ALU result waiting for the register-file write port.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd_address;
        logic [DATA_WIDTH-1:0] result;
        logic                  reg_write;
    } wb_entry_t;

    // A valid entry that will write a non-zero register matches a read address.
    function automatic logic fwd_match(input wb_entry_t             entry,
                                       input logic                  valid,
                                       input logic [ADDR_WIDTH-1:0] address);
        return valid && entry.reg_write && (address != ZERO_REG) &&
               (entry.rd_address == address);
    endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo2.sv
// wb_fifo2: two-entry FIFO of write-back entries.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   push_valid/push_entry  offered entry; push_ready = not full (state only)
//   pop_req                consumer may take the head this cycle
//   pop_fire               head is removed this cycle
//   head_valid/head_entry  oldest entry
//   second_valid/entry     younger entry (valid only when full)
module wb_fifo2
    import writeback_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push_valid,
    input  wb_entry_t push_entry,
    output logic      push_ready,
    input  logic      pop_req,
    output logic      pop_fire,
    output logic      head_valid,
    output wb_entry_t head_entry,
    output logic      second_valid,
    output wb_entry_t second_entry
);

    wb_entry_t  mem_q [FIFO_DEPTH];
    wb_entry_t  mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_fire;

    // No pass-through while full: ready depends only on the stored count.
    always_comb begin
        push_ready   = (count_q != 2'd2);
        push_fire    = push_valid && push_ready;
        pop_fire     = (count_q != 2'd0) && pop_req;
        head_valid   = (count_q != 2'd0);
        head_entry   = mem_q[rd_ptr_q];
        second_valid = (count_q == 2'd2);
        second_entry = mem_q[~rd_ptr_q];
    end

    // Next-state: write at tail, advance pointers modulo 2, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: buffers ALU results (up to two) and drives the register
// file write port, with rs/rt forwarding from pending results.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   in_valid/in_ready                   result handshake from the ALU side
//   in_rd_address/in_result/in_reg_write  offered result
//   wb_grant                            write port available this cycle
//   wb_write_enable/wb_rd_address/wb_data  register-file write port
//   fwd_rs_*/fwd_rt_*                   forwarding lookups (combinational)
//   retired_count                       number of register writes performed
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_rd_address,
    input  logic [DATA_WIDTH-1:0]  in_result,
    input  logic                   in_reg_write,
    input  logic                   wb_grant,
    output logic                   wb_write_enable,
    output logic [ADDR_WIDTH-1:0]  wb_rd_address,
    output logic [DATA_WIDTH-1:0]  wb_data,
    input  logic [ADDR_WIDTH-1:0]  fwd_rs_address,
    output logic                   fwd_rs_hit,
    output logic [DATA_WIDTH-1:0]  fwd_rs_data,
    input  logic [ADDR_WIDTH-1:0]  fwd_rt_address,
    output logic                   fwd_rt_hit,
    output logic [DATA_WIDTH-1:0]  fwd_rt_data,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    wb_entry_t push_entry;
    wb_entry_t head_entry;
    wb_entry_t second_entry;
    logic      head_valid;
    logic      second_valid;
    logic      pop_fire;

    logic [COUNT_WIDTH-1:0] retired_count_q, retired_count_d;

    logic rs_young_hit, rs_old_hit;
    logic rt_young_hit, rt_old_hit;

    always_comb begin
        push_entry.rd_address = in_rd_address;
        push_entry.result     = in_result;
        push_entry.reg_write  = in_reg_write;
    end

    wb_fifo2 u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (in_valid),
        .push_entry   (push_entry),
        .push_ready   (in_ready),
        .pop_req      (wb_grant),
        .pop_fire     (pop_fire),
        .head_valid   (head_valid),
        .head_entry   (head_entry),
        .second_valid (second_valid),
        .second_entry (second_entry)
    );

    // Write port: head always shown (zero when empty); strobe only for real writes.
    always_comb begin
        wb_write_enable = pop_fire && head_entry.reg_write &&
                          (head_entry.rd_address != ZERO_REG);
        wb_rd_address   = head_valid ? head_entry.rd_address : '0;
        wb_data         = head_valid ? head_entry.result     : '0;
    end

    // Forwarding: the younger (tail-side) entry takes priority over the head.
    // The head still hits while being written since the regfile updates at the edge.
    always_comb begin
        rs_young_hit = fwd_match(second_entry, second_valid, fwd_rs_address);
        rs_old_hit   = fwd_match(head_entry,   head_valid,   fwd_rs_address);
        rt_young_hit = fwd_match(second_entry, second_valid, fwd_rt_address);
        rt_old_hit   = fwd_match(head_entry,   head_valid,   fwd_rt_address);

        fwd_rs_hit  = rs_young_hit || rs_old_hit;
        fwd_rs_data = rs_young_hit ? second_entry.result :
                      rs_old_hit   ? head_entry.result   : '0;
        fwd_rt_hit  = rt_young_hit || rt_old_hit;
        fwd_rt_data = rt_young_hit ? second_entry.result :
                      rt_old_hit   ? head_entry.result   : '0;
    end

    // Retired-write counter wraps naturally at all-ones.
    always_comb begin
        retired_count_d = retired_count_q;
        if (wb_write_enable) begin
            retired_count_d = retired_count_q + COUNT_WIDTH'(1);
        end
        retired_count = retired_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

endmodule
